// File: rtl/sc_operand_latch_pkg.sv
// Shared definitions for the operand latch: FSM state encoding and slot-index sizing.
package sc_operand_latch_pkg;

    // Occupancy of the 2-entry elastic stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int NREGS_DEFAULT = 6;

    // Bits needed to index nregs slots (at least one bit).
    function automatic int slot_idx_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int SLOT_IDX_W = slot_idx_w(NREGS_DEFAULT);

endpackage

// File: rtl/sc_operand_select.sv
// Combinational NREGS:1 operand mux; out-of-range selects return zero and raise a flag.
module sc_operand_select
    import sc_operand_latch_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NREGS         = 6,
    parameter int SELWIDTH      = 3
) (
    input  logic [NREGS*DATAWIDTH_BUS-1:0] regs,
    input  logic [SELWIDTH-1:0]            sel,
    output logic [DATAWIDTH_BUS-1:0]       operand,
    output logic                           out_of_range
);

    // Compare width wide enough for both the select code and the slot count.
    localparam int IDX_W = slot_idx_w(NREGS);
    localparam int CMP_W = ((SELWIDTH > IDX_W) ? SELWIDTH : IDX_W) + 1;

    // Slot decode; anything not matching a real slot falls through to zero.
    always_comb begin
        operand      = '0;
        out_of_range = (CMP_W'(sel) >= CMP_W'(NREGS));
        for (int k = 0; k < NREGS; k++) begin
            if (CMP_W'(sel) == CMP_W'(k)) begin
                operand = regs[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            end
        end
    end

endmodule

// File: rtl/sc_operand_latch.sv
// Operand latch: selects A/B from the register bus and buffers pairs in a
// 2-entry elastic stage (output register + skid register) toward the ALU.
module sc_operand_latch
    import sc_operand_latch_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NREGS         = 6,
    parameter int SELWIDTH      = 3
) (
    input  logic                           SC_OperandLatch_CLOCK_50,
    input  logic                           SC_OperandLatch_RESET_InLow,
    input  logic [NREGS*DATAWIDTH_BUS-1:0] SC_OperandLatch_regs_InBus,
    input  logic [SELWIDTH-1:0]            SC_OperandLatch_selA_In,
    input  logic [SELWIDTH-1:0]            SC_OperandLatch_selB_In,
    input  logic                           SC_OperandLatch_inValid_In,
    output logic                           SC_OperandLatch_inReady_Out,
    output logic [DATAWIDTH_BUS-1:0]       SC_OperandLatch_opA_OutBus,
    output logic [DATAWIDTH_BUS-1:0]       SC_OperandLatch_opB_OutBus,
    output logic                           SC_OperandLatch_outValid_Out,
    input  logic                           SC_OperandLatch_outReady_In,
    output logic                           SC_OperandLatch_selErr_Out
);

    state_t                     state;
    state_t                     state_next;

    logic [DATAWIDTH_BUS-1:0]   sel_a_p0;
    logic [DATAWIDTH_BUS-1:0]   sel_b_p0;
    logic                       err_a_p0;
    logic                       err_b_p0;

    logic [DATAWIDTH_BUS-1:0]   out_a_p1;
    logic [DATAWIDTH_BUS-1:0]   out_b_p1;
    logic [DATAWIDTH_BUS-1:0]   skid_a_p1;
    logic [DATAWIDTH_BUS-1:0]   skid_b_p1;
    logic                       sel_err;

    logic                       in_ready;
    logic                       vld_p1;
    logic                       push;
    logic                       pop;

    sc_operand_select #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS),
        .NREGS         (NREGS),
        .SELWIDTH      (SELWIDTH)
    ) u_select_a (
        .regs         (SC_OperandLatch_regs_InBus),
        .sel          (SC_OperandLatch_selA_In),
        .operand      (sel_a_p0),
        .out_of_range (err_a_p0)
    );

    sc_operand_select #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS),
        .NREGS         (NREGS),
        .SELWIDTH      (SELWIDTH)
    ) u_select_b (
        .regs         (SC_OperandLatch_regs_InBus),
        .sel          (SC_OperandLatch_selB_In),
        .operand      (sel_b_p0),
        .out_of_range (err_b_p0)
    );

    // Handshake flags come from the state register only, so outReady never reaches inReady.
    assign in_ready = (state != FULL);
    assign vld_p1   = (state != EMPTY);
    assign push     = SC_OperandLatch_inValid_In & in_ready;
    assign pop      = vld_p1 & SC_OperandLatch_outReady_In;

    // Occupancy register.
    always_ff @(posedge SC_OperandLatch_CLOCK_50 or negedge SC_OperandLatch_RESET_InLow) begin
        if (!SC_OperandLatch_RESET_InLow) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode from push/pop.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (!push && pop) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // ---- stage p0 -> p1: operands sampled in the accept cycle into output or skid register
    always_ff @(posedge SC_OperandLatch_CLOCK_50 or negedge SC_OperandLatch_RESET_InLow) begin
        if (!SC_OperandLatch_RESET_InLow) begin
            out_a_p1  <= '0;
            out_b_p1  <= '0;
            skid_a_p1 <= '0;
            skid_b_p1 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_a_p1 <= sel_a_p0;
                        out_b_p1 <= sel_b_p0;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_a_p1 <= sel_a_p0;
                        out_b_p1 <= sel_b_p0;
                    end else if (push) begin
                        skid_a_p1 <= sel_a_p0;
                        skid_b_p1 <= sel_b_p0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_a_p1 <= skid_a_p1;
                        out_b_p1 <= skid_b_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error: set when an out-of-range select is actually accepted.
    always_ff @(posedge SC_OperandLatch_CLOCK_50 or negedge SC_OperandLatch_RESET_InLow) begin
        if (!SC_OperandLatch_RESET_InLow) begin
            sel_err <= 1'b0;
        end else if (push && (err_a_p0 || err_b_p0)) begin
            sel_err <= 1'b1;
        end
    end

    assign SC_OperandLatch_inReady_Out  = in_ready;
    assign SC_OperandLatch_outValid_Out = vld_p1;
    assign SC_OperandLatch_opA_OutBus   = out_a_p1;
    assign SC_OperandLatch_opB_OutBus   = out_b_p1;
    assign SC_OperandLatch_selErr_Out   = sel_err;

endmodule
